serial_adder: RTL and testbench

- Bit-serial, LSB-first binary adder; the addition counterpart of the team's full subtractor.
- Reuses a single full-adder cell (A xor B xor Cin; carry = AB | BCin | ACin) each clock, with a registered carry.
- Trades latency for area in the arithmetic library.
- Start/Done handshake; the result is held until the next operation completes.

---
 rtl/serial_adder.sv | 155 +++++++++++++++
 tb/tb_serial_adder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial, LSB-first binary adder built around a single
//                full-adder cell with a registered carry. A Start/Done
//                handshake frames each operation; the result registers hold
//                the last completed sum until the next operation finishes.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Start_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    input  logic                  Carry_In,
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic [DATA_WIDTH-1:0] Sum_Out,
    output logic                  Carry_Out,
    output logic                  Overflow_Out
);

    // Bit counter width is derived from the operand width.
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    // Counter value seen during the final (MSB) shift cycle.
    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [DATA_WIDTH-1:0]   r_a_sr;
    logic [DATA_WIDTH-1:0]   r_b_sr;
    logic [DATA_WIDTH-1:0]   r_sum_sr;
    logic                    r_carry;
    logic                    r_msb_cin;
    logic [CNT_WIDTH-1:0]    r_cnt;

    logic [DATA_WIDTH-1:0]   r_sum_out;
    logic                    r_carry_out;
    logic                    r_ovf_out;

    logic                    w_sum_bit;
    logic                    w_carry_next;
    logic                    w_last_bit;
    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_sum_shifted;

    // The shared full-adder cell operating on the current operand LSBs.
    assign w_sum_bit     = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_carry_next  = (r_a_sr[0] & r_b_sr[0]) |
                           (r_b_sr[0] & r_carry)   |
                           (r_a_sr[0] & r_carry);

    // Sum register fills from the MSB end so bit 0 lands at the LSB last.
    assign w_sum_shifted = {w_sum_bit, r_sum_sr[DATA_WIDTH-1:1]};

    assign w_last_bit    = (r_state == S_SHIFT) && (r_cnt == c_cnt_last);

    // A new operation may be accepted from IDLE or back-to-back from DONE.
    assign w_accept      = Start_In && ((r_state == S_IDLE) || (r_state == S_DONE));

    // State register.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start_In) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (Start_In) begin
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand shift registers, carry flop, counter and sum shift register.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_sum_sr  <= '0;
            r_carry   <= 1'b0;
            r_msb_cin <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_a_sr    <= Data_A_In;
            r_b_sr    <= Data_B_In;
            r_carry   <= Carry_In;
            r_cnt     <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sr    <= r_a_sr >> 1;
            r_b_sr    <= r_b_sr >> 1;
            r_sum_sr  <= w_sum_shifted;
            r_carry   <= w_carry_next;
            r_cnt     <= r_cnt + 1'b1;
            if (w_last_bit) begin
                // Carry into the MSB, kept for the overflow flag.
                r_msb_cin <= r_carry;
            end
        end
    end

    // Result registers: updated only on the edge that enters DONE.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_sum_out   <= '0;
            r_carry_out <= 1'b0;
            r_ovf_out   <= 1'b0;
        end else if (w_last_bit) begin
            r_sum_out   <= w_sum_shifted;
            r_carry_out <= w_carry_next;
            r_ovf_out   <= r_carry ^ w_carry_next;
        end
    end

    assign Busy_Out     = (r_state == S_SHIFT);
    assign Done_Out     = (r_state == S_DONE);
    assign Sum_Out      = r_sum_out;
    assign Carry_Out    = r_carry_out;
    assign Overflow_Out = r_ovf_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking directed testbench for serial_adder
//                (DATA_WIDTH = 8) with a random sweep against a reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int c_width = 8;

    logic               r_clk;
    logic               r_rst;
    logic               r_start;
    logic [c_width-1:0] r_a;
    logic [c_width-1:0] r_b;
    logic               r_cin;
    logic               w_busy;
    logic               w_done;
    logic [c_width-1:0] w_sum;
    logic               w_carry;
    logic               w_ovf;

    int n_checks;
    int n_errors;
    logic [c_width-1:0] r_prev_sum;

    serial_adder #(
        .DATA_WIDTH (c_width)
    ) u_dut (
        .Clock_In     (r_clk),
        .Reset_In     (r_rst),
        .Start_In     (r_start),
        .Data_A_In    (r_a),
        .Data_B_In    (r_b),
        .Carry_In     (r_cin),
        .Busy_Out     (w_busy),
        .Done_Out     (w_done),
        .Sum_Out      (w_sum),
        .Carry_Out    (w_carry),
        .Overflow_Out (w_ovf)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete operation with cycle-accurate handshake checks.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] exp_sum, input logic exp_c, input logic exp_v);
        r_a = a; r_b = b; r_cin = cin; r_start = 1'b1;
        tick();
        r_start = 1'b0;
        r_a = 8'($urandom); r_b = 8'($urandom); r_cin = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            check("busy", 32'(w_busy), 32'd1);
            check("done_early", 32'(w_done), 32'd0);
            check("sum_hold", 32'(w_sum), 32'(r_prev_sum));
            tick();
        end
        check("done", 32'(w_done), 32'd1);
        check("busy_at_done", 32'(w_busy), 32'd0);
        check("sum", 32'(w_sum), 32'(exp_sum));
        check("carry", 32'(w_carry), 32'(exp_c));
        check("ovf", 32'(w_ovf), 32'(exp_v));
        r_prev_sum = exp_sum;
        tick();
        check("done_pulse_end", 32'(w_done), 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] full;
        logic       vref;
        int         dones;

        n_checks = 0; n_errors = 0; r_prev_sum = '0;
        r_rst = 1'b1; r_start = 1'b0; r_a = '0; r_b = '0; r_cin = 1'b0;
        tick(); tick();
        r_rst = 1'b0;
        check("rst_busy", 32'(w_busy), 32'd0);
        check("rst_done", 32'(w_done), 32'd0);
        check("rst_sum", 32'(w_sum), 32'd0);
        check("rst_carry", 32'(w_carry), 32'd0);
        check("rst_ovf", 32'(w_ovf), 32'd0);
        tick();
        check("idle_busy", 32'(w_busy), 32'd0);

        // Directed vectors.
        run_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Start held high: back-to-back operations.
        r_a = 8'h01; r_b = 8'h02; r_cin = 1'b0; r_start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("b2b_busy1", 32'(w_busy), 32'd1);
            tick();
        end
        check("b2b_done1", 32'(w_done), 32'd1);
        check("b2b_sum1", 32'(w_sum), 32'h03);
        r_a = 8'h10; r_b = 8'h20;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (w_done) dones++;
            check("b2b_hold", 32'(w_sum), 32'h03);
        end
        check("b2b_no_early_done", 32'(dones), 32'd0);
        tick();
        check("b2b_done2", 32'(w_done), 32'd1);
        check("b2b_sum2", 32'(w_sum), 32'h30);
        r_start = 1'b0;
        r_prev_sum = 8'h30;
        tick();
        check("b2b_idle", 32'(w_busy | w_done), 32'd0);

        // Start during SHIFT is ignored.
        r_a = 8'h11; r_b = 8'h22; r_cin = 1'b0; r_start = 1'b1;
        tick();
        r_start = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                r_start = 1'b1; r_a = 8'h77; r_b = 8'h77;
            end else begin
                r_start = 1'b0;
            end
            if (w_done) dones++;
            tick();
        end
        r_start = 1'b0;
        check("ign_no_early_done", 32'(dones), 32'd0);
        check("ign_done", 32'(w_done), 32'd1);
        check("ign_sum", 32'(w_sum), 32'h33);
        r_prev_sum = 8'h33;
        tick();
        check("ign_no_restart", 32'(w_busy | w_done), 32'd0);

        // Reset mid-SHIFT aborts the operation.
        r_a = 8'h80; r_b = 8'h80; r_cin = 1'b0; r_start = 1'b1;
        tick();
        r_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_busy_before", 32'(w_busy), 32'd1);
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        check("abort_busy", 32'(w_busy), 32'd0);
        check("abort_done", 32'(w_done), 32'd0);
        check("abort_sum", 32'(w_sum), 32'd0);
        check("abort_carry", 32'(w_carry), 32'd0);
        check("abort_ovf", 32'(w_ovf), 32'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (w_done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        r_prev_sum = 8'h00;
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Random sweep against a behavioural reference.
        for (int n = 0; n < 256; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            vref = (ra[7] == rb[7]) && (full[7] != ra[7]);
            run_op(ra, rb, rc, full[7:0], full[8], vref);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
